// File: rtl/fifo_rd_packer_pkg.sv
// Shared configuration, state encoding and lane-mask helper for the FIFO read-side packer.
// DATA_WIDTH and PACK_RATIO set the lane width and lanes per beat for every file of the block.
package fifo_rd_packer_pkg;

    localparam int DATA_WIDTH = 8;
    localparam int PACK_RATIO = 4;
    localparam int CNT_W      = $clog2(PACK_RATIO);
    localparam int BEAT_W     = DATA_WIDTH * PACK_RATIO;

    typedef enum logic {
        FILL  = 1'b0,
        FLUSH = 1'b1
    } state_t;

    // Mask with the low n lanes set; n never reaches PACK_RATIO.
    function automatic logic [PACK_RATIO-1:0] keep_mask(input logic [CNT_W-1:0] n);
        logic [PACK_RATIO-1:0] m;
        m = '0;
        for (int i = 0; i < PACK_RATIO; i++) begin
            if (CNT_W'(i) < n) m[i] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/fifo_rd_packer_if.sv
// FIFO read port, flush control and packed-beat stream of the read-side packer.
// m_valid/m_ready: a beat transfers on a rising edge where both are high; once m_valid is up,
// m_valid, m_data, m_keep and m_last stay unchanged until that transfer happens.
interface fifo_rd_packer_if;
    import fifo_rd_packer_pkg::*;

    logic                  fifo_empty;
    logic [DATA_WIDTH-1:0] fifo_data;
    logic                  fifo_rd_en;
    logic                  flush;
    logic [BEAT_W-1:0]     m_data;
    logic [PACK_RATIO-1:0] m_keep;
    logic                  m_last;
    logic                  m_valid;
    logic                  m_ready;
    logic                  flush_done;
    state_t                state;
    logic [CNT_W-1:0]      cnt;

    modport master (
        input  fifo_empty, fifo_data, flush, m_ready,
        output fifo_rd_en, m_data, m_keep, m_last, m_valid, flush_done, state, cnt
    );

    modport slave (
        output fifo_empty, fifo_data, flush, m_ready,
        input  fifo_rd_en, m_data, m_keep, m_last, m_valid, flush_done, state, cnt
    );

endinterface

// File: rtl/fifo_rd_packer_out.sv
// Valid/ready holding register for packed beats; a load is only issued while out_free is high.
module pack_out_reg
    import fifo_rd_packer_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [BEAT_W-1:0]     load_data,
    input  logic [PACK_RATIO-1:0] load_keep,
    input  logic                  load_last,
    input  logic                  ready,
    output logic                  valid,
    output logic [BEAT_W-1:0]     data,
    output logic [PACK_RATIO-1:0] keep,
    output logic                  last,
    output logic                  out_free
);

    assign out_free = !valid || ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= 1'b0;
            data  <= '0;
            keep  <= '0;
            last  <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= load_data;
            keep  <= load_keep;
            last  <= load_last;
        end else if (ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/fifo_rd_packer.sv
// Drains a show-ahead FIFO, packs PACK_RATIO words per beat, and emits a partial
// last beat with a keep mask when flushed.
module fifo_rd_packer
    import fifo_rd_packer_pkg::*;
(
    input  logic             rd_clk,
    input  logic             rst,
    fifo_rd_packer_if.master bus
);

    localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(PACK_RATIO - 1);

    state_t                state;
    logic [CNT_W-1:0]      cnt;
    logic [DATA_WIDTH-1:0] acc [PACK_RATIO];
    logic                  flush_done;

    logic                  out_free;
    logic                  pop;
    logic                  load;
    logic [BEAT_W-1:0]     load_data;
    logic [PACK_RATIO-1:0] load_keep;
    logic                  load_last;
    logic [PACK_RATIO-1:0] flush_keep;

    assign flush_keep = keep_mask(cnt);

    // The top lane never sits in acc: the completing word goes straight into the beat,
    // which is why that pop alone must wait for the output register to be free.
    assign pop = !rst && (state == FILL) && !bus.fifo_empty && ((cnt != LAST_LANE) || out_free);

    assign bus.fifo_rd_en = pop;
    assign bus.flush_done = flush_done;
    assign bus.state      = state;
    assign bus.cnt        = cnt;

    always_comb begin
        load      = 1'b0;
        load_data = '0;
        load_keep = '0;
        load_last = 1'b0;
        if (state == FILL) begin
            if (pop && (cnt == LAST_LANE)) begin
                load = 1'b1;
                for (int i = 0; i < PACK_RATIO - 1; i++) begin
                    load_data[i*DATA_WIDTH +: DATA_WIDTH] = acc[i];
                end
                load_data[BEAT_W-1 -: DATA_WIDTH] = bus.fifo_data;
                load_keep = '1;
            end
        end else if (out_free && (cnt != '0)) begin
            load = 1'b1;
            for (int i = 0; i < PACK_RATIO; i++) begin
                if (flush_keep[i]) load_data[i*DATA_WIDTH +: DATA_WIDTH] = acc[i];
            end
            load_keep = flush_keep;
            load_last = 1'b1;
        end
    end

    always_ff @(posedge rd_clk or posedge rst) begin
        if (rst) begin
            state      <= FILL;
            cnt        <= '0;
            flush_done <= 1'b0;
            for (int i = 0; i < PACK_RATIO; i++) acc[i] <= '0;
        end else begin
            flush_done <= 1'b0;
            case (state)
                FILL: begin
                    if (pop) begin
                        if (cnt == LAST_LANE) begin
                            cnt <= '0;
                        end else begin
                            acc[cnt] <= bus.fifo_data;
                            cnt      <= cnt + 1'b1;
                        end
                    end
                    if (bus.flush) state <= FLUSH;
                end
                FLUSH: begin
                    if (out_free) begin
                        cnt        <= '0;
                        flush_done <= 1'b1;
                        state      <= FILL;
                    end
                end
            endcase
        end
    end

    pack_out_reg u_out (
        .clk       (rd_clk),
        .rst       (rst),
        .load      (load),
        .load_data (load_data),
        .load_keep (load_keep),
        .load_last (load_last),
        .ready     (bus.m_ready),
        .valid     (bus.m_valid),
        .data      (bus.m_data),
        .keep      (bus.m_keep),
        .last      (bus.m_last),
        .out_free  (out_free)
    );

endmodule
